// File: rtl/argmax_pkg.sv
// +----------------------------------------------------------------+
// | argmax_pkg: shared types and helpers for the argmax output stage |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

package argmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int c_MAX_SCORE_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Lowest score the comparator can see; seeds the runner-up slot.
  function automatic logic [c_MAX_SCORE_W-1:0] min_score(input bit signed_cmp, input int width);
    return signed_cmp ? (64'd1 << (width - 1)) : 64'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/argmax_cmp.sv
// +----------------------------------------------------------------+
// | argmax_cmp: decides whether score a displaces score b            |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int SIZE_1     = 16,
  parameter int SIGNED_CMP = 1,
  parameter int TIE_LAST   = 1
) (
  input  logic [SIZE_1-1:0] a,
  input  logic [SIZE_1-1:0] b,
  output logic              beats
);

  logic w_gt;
  logic w_eq;

  generate
    if (SIGNED_CMP != 0) begin : g_signed
      assign w_gt = $signed(a) > $signed(b);
    end else begin : g_unsigned
      assign w_gt = a > b;
    end
  endgenerate

  // a always arrives later than b, so a tie goes to a only when the later index wins
  assign w_eq  = (a == b);
  assign beats = w_gt | (w_eq & (TIE_LAST != 0));

endmodule

`default_nettype wire

// File: rtl/argmax_result.sv
// +----------------------------------------------------------------+
// | argmax_result: streams class scores from memory, reports best    |
// | and runner-up index/score. Rev 1.0                               |
// +----------------------------------------------------------------+
`default_nettype none

module argmax_result
  import argmax_pkg::*;
#(
  parameter int SIZE_1           = 16,
  parameter int SIZE_address_pix = 13,
  parameter int NUM_CLASSES      = 11,
  parameter int CLASS_W          = 4,
  parameter int READ_LATENCY     = 1,
  parameter int SIGNED_CMP       = 1,
  parameter int TIE_LAST         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [SIZE_address_pix-1:0] memstartp,
  input  logic [SIZE_1-1:0]           qp,
  output logic                        re,
  output logic [SIZE_address_pix-1:0] read_addressp,
  output logic [CLASS_W-1:0]          RESULT,
  output logic [SIZE_1-1:0]           max_value,
  output logic [CLASS_W-1:0]          RESULT2,
  output logic [SIZE_1-1:0]           second_value,
  output logic                        STOP
);

  localparam int c_CNT_W = (clog2(NUM_CLASSES + 1) > CLASS_W) ? clog2(NUM_CLASSES + 1) : CLASS_W;
  localparam int c_LAST  = READ_LATENCY - 1;
  localparam logic [c_CNT_W-1:0] c_N   = c_CNT_W'(NUM_CLASSES);
  localparam logic [SIZE_1-1:0]  c_MIN = SIZE_1'(min_score(SIGNED_CMP != 0, SIZE_1));

  state_t                      r_state;
  logic [SIZE_address_pix-1:0] r_base;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_CNT_W-1:0]          r_rcv;
  logic                        r_tv [READ_LATENCY];
  logic [CLASS_W-1:0]          r_ti [READ_LATENCY];
  logic [SIZE_1-1:0]           r_best_v;
  logic [SIZE_1-1:0]           r_sec_v;
  logic [CLASS_W-1:0]          r_best_i;
  logic [CLASS_W-1:0]          r_sec_i;

  logic                        w_push_v;
  logic [CLASS_W-1:0]          w_push_i;
  logic                        w_beat_best;
  logic                        w_beat_sec;

  assign w_push_v = enable && ((r_state == ST_IDLE) || ((r_state == ST_RUN) && (r_cnt < c_N)));
  assign w_push_i = (r_state == ST_IDLE) ? '0 : r_cnt[CLASS_W-1:0];

  argmax_cmp #(.SIZE_1(SIZE_1), .SIGNED_CMP(SIGNED_CMP), .TIE_LAST(TIE_LAST)) u_cmp_best (
    .a     (qp),
    .b     (r_best_v),
    .beats (w_beat_best)
  );

  argmax_cmp #(.SIZE_1(SIZE_1), .SIGNED_CMP(SIGNED_CMP), .TIE_LAST(TIE_LAST)) u_cmp_sec (
    .a     (qp),
    .b     (r_sec_v),
    .beats (w_beat_sec)
  );

  // Each issued read carries a valid/index tag that lines up with its data on qp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tv[i] <= 1'b0;
        r_ti[i] <= '0;
      end
    end else if (!enable) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tv[i] <= 1'b0;
        r_ti[i] <= '0;
      end
    end else begin
      r_tv[0] <= w_push_v;
      r_ti[0] <= w_push_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_ti[i] <= r_ti[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_base        <= '0;
      r_cnt         <= '0;
      r_rcv         <= '0;
      r_best_v      <= '0;
      r_best_i      <= '0;
      r_sec_v       <= '0;
      r_sec_i       <= '0;
      re            <= 1'b0;
      read_addressp <= '0;
      RESULT        <= '0;
      max_value     <= '0;
      RESULT2       <= '0;
      second_value  <= '0;
      STOP          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state       <= ST_RUN;
            re            <= 1'b1;
            read_addressp <= memstartp;
            r_base        <= memstartp;
            r_cnt         <= c_CNT_W'(1);
            r_rcv         <= '0;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            re      <= 1'b0;
            STOP    <= 1'b0;
            r_cnt   <= '0;
            r_rcv   <= '0;
          end else begin
            if (r_cnt < c_N) begin
              read_addressp <= r_base + SIZE_address_pix'(r_cnt);
              r_cnt         <= r_cnt + c_CNT_W'(1);
            end else begin
              re <= 1'b0;
            end

            if (r_tv[c_LAST]) begin
              r_rcv <= r_rcv + c_CNT_W'(1);
              // First score seeds the max directly so all-negative vectors work.
              if (r_rcv == '0) begin
                r_best_v <= qp;
                r_best_i <= '0;
                r_sec_v  <= c_MIN;
                r_sec_i  <= '0;
              end else if (w_beat_best) begin
                r_sec_v  <= r_best_v;
                r_sec_i  <= r_best_i;
                r_best_v <= qp;
                r_best_i <= r_ti[c_LAST];
              end else if (w_beat_sec) begin
                r_sec_v <= qp;
                r_sec_i <= r_ti[c_LAST];
              end
            end

            if (r_rcv == c_N) begin
              RESULT       <= r_best_i;
              max_value    <= r_best_v;
              RESULT2      <= r_sec_i;
              second_value <= r_sec_v;
              STOP         <= 1'b1;
              r_state      <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            re      <= 1'b0;
            STOP    <= 1'b0;
            r_cnt   <= '0;
            r_rcv   <= '0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          re      <= 1'b0;
          STOP    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_argmax_result.sv
// +----------------------------------------------------------------+
// | tb_argmax_result: four configurations share one score memory     |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
`default_nettype none

module tb_argmax_result;

  localparam int N = 11;

  typedef struct packed {
    logic [3:0]  res;
    logic [15:0] mx;
    logic [3:0]  res2;
    logic [15:0] sec;
  } exp_t;
  typedef exp_t [3:0] exps_t;
  typedef struct packed {
    logic [12:0]        base;
    logic [0:10][15:0]  s;
    exp_t               ea;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [12:0] memstartp;
  logic [15:0] qa, qb, qc, qd;
  logic [3:0]  re_o, stop_o;
  logic [3:0][12:0] addr_o;
  logic [3:0][3:0]  res_o, res2_o;
  logic [3:0][15:0] mx_o, sec_o;

  logic [15:0] mem [8192];
  logic [15:0] d_p1, d_p2;
  logic [0:10][15:0] cur;
  logic [3:0] prev_res;
  vec_t  tbl [5];
  exps_t sbq [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // A/B/C see data one edge after the address; D sees it three edges after.
  assign qa = mem[addr_o[0]];
  assign qb = mem[addr_o[1]];
  assign qc = mem[addr_o[2]];
  always @(posedge clk) begin
    d_p1 <= mem[addr_o[3]];
    d_p2 <= d_p1;
  end
  assign qd = d_p2;

  argmax_result #(.READ_LATENCY(1), .SIGNED_CMP(1), .TIE_LAST(1)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .memstartp(memstartp), .qp(qa),
    .re(re_o[0]), .read_addressp(addr_o[0]), .RESULT(res_o[0]), .max_value(mx_o[0]),
    .RESULT2(res2_o[0]), .second_value(sec_o[0]), .STOP(stop_o[0]));
  argmax_result #(.READ_LATENCY(1), .SIGNED_CMP(1), .TIE_LAST(0)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .memstartp(memstartp), .qp(qb),
    .re(re_o[1]), .read_addressp(addr_o[1]), .RESULT(res_o[1]), .max_value(mx_o[1]),
    .RESULT2(res2_o[1]), .second_value(sec_o[1]), .STOP(stop_o[1]));
  argmax_result #(.READ_LATENCY(1), .SIGNED_CMP(0), .TIE_LAST(1)) u_c (
    .clk(clk), .rst(rst), .enable(enable), .memstartp(memstartp), .qp(qc),
    .re(re_o[2]), .read_addressp(addr_o[2]), .RESULT(res_o[2]), .max_value(mx_o[2]),
    .RESULT2(res2_o[2]), .second_value(sec_o[2]), .STOP(stop_o[2]));
  argmax_result #(.READ_LATENCY(3), .SIGNED_CMP(1), .TIE_LAST(1)) u_d (
    .clk(clk), .rst(rst), .enable(enable), .memstartp(memstartp), .qp(qd),
    .re(re_o[3]), .read_addressp(addr_o[3]), .RESULT(res_o[3]), .max_value(mx_o[3]),
    .RESULT2(res2_o[3]), .second_value(sec_o[3]), .STOP(stop_o[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference ordering: value first, then index according to the tie rule.
  function automatic bit mbeats(input logic [15:0] a, input int ia, input logic [15:0] b,
                                input int ib, input bit sg, input bit tl);
    if (sg ? ($signed(a) > $signed(b)) : (a > b)) return 1'b1;
    if (a != b) return 1'b0;
    return tl ? (ia > ib) : (ia < ib);
  endfunction

  function automatic exp_t model(input bit sg, input bit tl);
    int b;
    int s;
    exp_t e;
    b = 0;
    s = -1;
    for (int k = 1; k < N; k++) if (mbeats(cur[k], k, cur[b], b, sg, tl)) b = k;
    for (int k = 0; k < N; k++)
      if (k != b && (s < 0 || mbeats(cur[k], k, cur[s], s, sg, tl))) s = k;
    e.res  = 4'(b);
    e.mx   = cur[b];
    e.res2 = 4'(s);
    e.sec  = cur[s];
    return e;
  endfunction

  task automatic load(input vec_t v);
    cur = v.s;
    for (int k = 0; k < N; k++) mem[v.base + 13'(k)] = v.s[k];
  endtask

  task automatic run(input int vi, input bit keep);
    exps_t e;
    vec_t  v;
    int ta;
    int td;
    v = tbl[vi];
    load(v);
    e[0] = v.ea;
    e[1] = model(1'b1, 1'b0);
    e[2] = model(1'b0, 1'b1);
    e[3] = v.ea;
    sbq.push_back(e);
    @(negedge clk);
    memstartp = v.base;
    enable    = 1'b1;
    ta = -1;
    td = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j < N) begin
        chk($sformatf("re_on v%0d j%0d", vi, j), 32'(re_o[0]), 32'd1);
        chk($sformatf("addr v%0d j%0d", vi, j), 32'(addr_o[0]), 32'(13'(v.base + 13'(j))));
      end
      if (j == N) begin
        chk($sformatf("re_off v%0d", vi), 32'(re_o[0]), 32'd0);
        chk($sformatf("res_hold v%0d", vi), 32'(res_o[0]), 32'(prev_res));
      end
      if (stop_o[0] && ta < 0) ta = j;
      if (stop_o[3] && td < 0) td = j;
    end
    chk($sformatf("stop_edge_lat1 v%0d", vi), 32'(ta), 32'd12);
    chk($sformatf("stop_edge_lat3 v%0d", vi), 32'(td), 32'd14);
    e = sbq.pop_front();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("RESULT v%0d dut%0d", vi, i), 32'(res_o[i]), 32'(e[i].res));
      chk($sformatf("max_value v%0d dut%0d", vi, i), 32'(mx_o[i]), 32'(e[i].mx));
      chk($sformatf("RESULT2 v%0d dut%0d", vi, i), 32'(res2_o[i]), 32'(e[i].res2));
      chk($sformatf("second_value v%0d dut%0d", vi, i), 32'(sec_o[i]), 32'(e[i].sec));
    end
    prev_res = e[0].res;
    chk($sformatf("stop_held v%0d", vi), 32'(stop_o[0]), 32'd1);
    if (!keep) begin
      enable = 1'b0;
      @(negedge clk);
      chk($sformatf("stop_clr v%0d", vi), 32'(stop_o[0]), 32'd0);
    end
  endtask

  initial begin
    int seen;
    tbl[0] = {13'd100, {16'd3, 16'd9, 16'd1, 16'd9, 16'd0, 16'd2, 16'd5, 16'd4, 16'd8, 16'd7, 16'd6},
              {4'd3, 16'd9, 4'd1, 16'd9}};
    tbl[1] = {13'd200, {16'hFFFB, 16'hFFFE, 16'hFFF7, 16'hFFFD, 16'hFFFC, 16'hFFFA, 16'hFFF8,
                        16'hFFF6, 16'hFFF5, 16'hFFF4, 16'hFFF9},
              {4'd1, 16'hFFFE, 4'd3, 16'hFFFD}};
    tbl[2] = {13'd300, {16'hFFFE, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10},
              {4'd10, 16'd10, 4'd9, 16'd9}};
    tbl[3] = {13'd8190, {16'd20, 16'd19, 16'd18, 16'd17, 16'd16, 16'd15, 16'd14, 16'd13, 16'd12,
                         16'd11, 16'd10},
              {4'd0, 16'd20, 4'd1, 16'd19}};
    tbl[4] = {13'd400, {11{16'd5}}, {4'd10, 16'd5, 4'd9, 16'd5}};

    for (int i = 0; i < 8192; i++) mem[i] = 16'd0;
    rst = 1'b1;
    enable = 1'b0;
    memstartp = '0;
    prev_res = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset re", 32'(re_o[0]), 32'd0);
    chk("reset addr", 32'(addr_o[0]), 32'd0);
    chk("reset RESULT", 32'(res_o[0]), 32'd0);
    chk("reset max_value", 32'(mx_o[0]), 32'd0);
    chk("reset RESULT2", 32'(res2_o[0]), 32'd0);
    chk("reset second_value", 32'(sec_o[0]), 32'd0);
    chk("reset STOP", 32'(stop_o), 32'd0);

    for (int vi = 0; vi < 5; vi++) run(vi, 1'b0);

    // Abort: enable seen low at e0+5; nothing may complete or change.
    load(tbl[1]);
    @(negedge clk);
    memstartp = tbl[1].base;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (stop_o != 4'd0) seen++;
    end
    chk("abort STOP", 32'(seen), 32'd0);
    chk("abort re", 32'(re_o[0]), 32'd0);
    chk("abort RESULT kept", 32'(res_o[0]), 32'(prev_res));
    chk("abort max_value kept", 32'(mx_o[0]), 32'd5);

    run(1, 1'b1);

    // Asynchronous reset between edges while in DONE.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst STOP", 32'(stop_o), 32'd0);
    chk("async rst re", 32'(re_o), 32'd0);
    chk("async rst RESULT", 32'(res_o[0]), 32'd0);
    chk("async rst max_value", 32'(mx_o[0]), 32'd0);
    chk("async rst addr", 32'(addr_o[0]), 32'd0);
    enable = 1'b0;
    #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post rst idle STOP", 32'(stop_o), 32'd0);
    chk("post rst idle re", 32'(re_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
